instr_encoder: RTL and testbench

Sequential ARM instruction encoder and instruction-memory writer: the producer side of the processor's decoder. It accepts field-level instruction descriptions (class, command, S/I/L bits, registers, operands) over a valid/ready handshake. It packs each into the 32-bit machine word the decoder consumes, writes it to instruction memory at consecutive word addresses, and optionally reads it back to verify. It sits between the test/boot loader and the instruction memory, ahead of processor release from reset.

---
 rtl/instr_encoder_if.sv | 28 ++
 rtl/instr_encoder.sv | 182 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Field-level instruction channel between a loader (master) and the encoder (slave).
// in_valid/in_ready handshake; all fields are sampled on the accepting edge.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 6
) ();
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_cond;
  logic [1:0]        in_op;
  logic [3:0]        in_cmd;
  logic              in_s;
  logic              in_i;
  logic              in_l;
  logic [3:0]        in_rd;
  logic [3:0]        in_rn;
  logic [11:0]       in_src;
  logic [ADDR_W-1:0] in_target;

  modport master (
    output in_valid, in_cond, in_op, in_cmd, in_s, in_i, in_l, in_rd, in_rn, in_src, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_cond, in_op, in_cmd, in_s, in_i, in_l, in_rd, in_rn, in_src, in_target,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs field-level ARM instruction descriptions into 32-bit words and writes them to
// consecutive instruction-memory addresses, optionally reading each word back to verify.
module instr_encoder #(
  parameter int unsigned ADDR_W = 6,
  parameter bit          VERIFY = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  instr_encoder_if.slave      in_if,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output logic [ADDR_W:0]     wr_count,
  output logic                full,
  output logic                err,
  output logic [1:0]          err_code
);

  localparam logic [ADDR_W:0] FullCount = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {StIdle, StEnc, StWrite, StCheck} state_e;

  typedef struct packed {
    logic [3:0]        cond;
    logic [1:0]        op;
    logic [3:0]        cmd;
    logic              s;
    logic              i;
    logic              l;
    logic [3:0]        rd;
    logic [3:0]        rn;
    logic [11:0]       src;
    logic [ADDR_W-1:0] target;
  } fields_t;

  state_e            state_q, state_d;
  fields_t           f_q;
  logic              accept;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              ready;
  logic              advance;

  // Encoder datapath from the latched fields
  logic [31:0]       enc_word;
  logic              unsup;
  logic              s_eff;
  logic [3:0]        rd_eff, rn_eff;
  logic [11:0]       src2;
  logic [ADDR_W+1:0] br_off;
  logic [23:0]       imm24;

  assign full      = (cnt_q == FullCount);
  assign ready     = reset_n & (state_q == StIdle) & ~full & ~err_q;
  assign in_if.in_ready = ready;
  assign mem_we    = (state_q == StWrite);
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign wr_count  = cnt_q;
  assign err       = err_q;
  assign err_code  = code_q;

  // Offset is relative to the branch's own address plus two words; the true value always
  // fits in ADDR_W+2 two's-complement bits, so plain wrapping subtraction is exact.
  assign br_off = {2'b00, f_q.target} - {2'b00, addr_q} - (ADDR_W + 2)'(2);
  assign imm24  = {{(24 - ADDR_W - 2){br_off[ADDR_W+1]}}, br_off};

  always_comb begin
    enc_word = '0;
    unsup    = 1'b0;
    s_eff    = f_q.s;
    rd_eff   = f_q.rd;
    rn_eff   = f_q.rn;
    src2     = f_q.i ? f_q.src : {8'b0, f_q.src[3:0]};
    unique case (f_q.op)
      2'b00: begin
        unique case (f_q.cmd)
          4'b0100, 4'b0010, 4'b0000, 4'b1100: ;
          4'b1101: rn_eff = '0;
          4'b1010: begin
            s_eff  = 1'b1;
            rd_eff = '0;
          end
          default: unsup = 1'b1;
        endcase
        enc_word = {f_q.cond, 2'b00, f_q.i, f_q.cmd, s_eff, rn_eff, rd_eff, src2};
      end
      2'b01:   enc_word = {f_q.cond, 3'b010, 4'b1100, f_q.l, f_q.rn, f_q.rd, f_q.src};
      2'b10:   enc_word = {f_q.cond, 4'b1010, imm24};
      default: unsup = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    code_d  = code_q;
    accept  = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d = '0;
          cnt_d  = '0;
          err_d  = 1'b0;
          code_d = 2'b00;
        end else if (in_if.in_valid && ready) begin
          accept  = 1'b1;
          state_d = StEnc;
        end
      end
      StEnc: begin
        if (unsup) begin
          err_d   = 1'b1;
          code_d  = 2'b01;
          state_d = StIdle;
        end else begin
          word_d  = enc_word;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (VERIFY) begin
          state_d = StCheck;
        end else begin
          advance = 1'b1;
          state_d = StIdle;
        end
      end
      StCheck: begin
        if (mem_rdata != word_q) begin
          err_d  = 1'b1;
          code_d = 2'b10;
        end
        advance = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (advance) begin
      addr_d = addr_q + 1'b1;
      cnt_d  = full ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      word_q  <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_q <= '0;
    end else if (accept) begin
      f_q <= '{cond: in_if.in_cond, op: in_if.in_op, cmd: in_if.in_cmd, s: in_if.in_s,
               i: in_if.in_i, l: in_if.in_l, rd: in_if.in_rd, rn: in_if.in_rn,
               src: in_if.in_src, target: in_if.in_target};
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed test-plan cases plus randomized transactions, all checked
// every cycle against a transaction-level model of the encoder.
module tb_instr_encoder;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [AW:0]   wr_count;
  logic          full;
  logic          err;
  logic [1:0]    err_code;
  logic [31:0]   corrupt_mask = 32'h0;
  logic [31:0]   mem [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW), .VERIFY(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in_if     (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .wr_count  (wr_count),
    .full      (full),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr] ^ corrupt_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference encoding from the instruction-set rules, as {unsupported, word}.
  function automatic logic [32:0] encode(input logic [1:0] op, input logic [3:0] cmd,
                                         input logic [3:0] cond, input logic s, input logic i,
                                         input logic l, input logic [3:0] rd,
                                         input logic [3:0] rn, input logic [11:0] src,
                                         input int target, input int addr);
    logic [31:0] w;
    logic        uns;
    logic [31:0] sv, rdv, rnv, s2;
    int          off;
    w = 0; uns = 0; sv = 32'(s); rdv = 32'(rd); rnv = 32'(rn);
    case (op)
      2'd0: begin
        if (!(cmd inside {4'h4, 4'h2, 4'h0, 4'hC, 4'hD, 4'hA})) uns = 1;
        if (cmd == 4'hA) begin sv = 1; rdv = 0; end
        if (cmd == 4'hD) rnv = 0;
        s2 = i ? 32'(src) : 32'(src) % 16;
        w = (32'(cond) << 28) | (32'(i) << 25) | (32'(cmd) << 21) | (sv << 20) | (rnv << 16)
          | (rdv << 12) | s2;
      end
      2'd1: w = (32'(cond) << 28) | (32'h1 << 26) | (32'h1 << 24) | (32'h1 << 23)
              | (32'(l) << 20) | (32'(rn) << 16) | (32'(rd) << 12) | 32'(src);
      2'd2: begin
        off = target - (addr + 2);
        w = (32'(cond) << 28) | (32'hA << 24) | (32'(off) & 32'h00FF_FFFF);
      end
      default: uns = 1;
    endcase
    return {uns, w};
  endfunction

  // Transaction model: phase counts cycles since acceptance (0 = idle).
  int            m_phase;
  logic [AW-1:0] m_addr;
  int            m_cnt;
  logic          m_err;
  logic [1:0]    m_code;
  logic [31:0]   m_wdata, m_pend;
  logic          m_unsup;
  logic          m_ready;

  assign m_ready = reset_n && m_phase == 0 && m_cnt != DEPTH && !m_err;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0; m_addr <= '0; m_cnt <= 0; m_err <= 0; m_code <= 0;
      m_wdata <= 0; m_pend <= 0; m_unsup <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_addr <= '0; m_cnt <= 0; m_err <= 0; m_code <= 0;
           end else if (bus.in_valid && m_ready) begin
             {m_unsup, m_pend} <= encode(bus.in_op, bus.in_cmd, bus.in_cond, bus.in_s, bus.in_i,
                                         bus.in_l, bus.in_rd, bus.in_rn, bus.in_src,
                                         int'(bus.in_target), int'(m_addr));
             m_phase <= 1;
           end
        1: if (m_unsup) begin
             m_err <= 1; m_code <= 2'd1; m_phase <= 0;
           end else begin
             m_wdata <= m_pend; m_phase <= 2;
           end
        2: m_phase <= 3;
        default: begin
          if (corrupt_mask != 0) begin m_err <= 1; m_code <= 2'd2; end
          m_addr  <= m_addr + 1'b1;
          m_cnt   <= (m_cnt == DEPTH) ? m_cnt : m_cnt + 1;
          m_phase <= 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_ready));
      chk("mem_we", 32'(mem_we), 32'(m_phase == 2 && reset_n));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("wr_count", 32'(wr_count), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == DEPTH));
      chk("err", 32'(err), 32'(m_err));
      chk("err_code", 32'(err_code), 32'(m_code));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [1:0] op, input logic [3:0] cmd, input logic [3:0] cond,
                            input logic s, input logic i, input logic l, input logic [3:0] rd,
                            input logic [3:0] rn, input logic [11:0] src, input int target);
    bus.in_op = op; bus.in_cmd = cmd; bus.in_cond = cond; bus.in_s = s; bus.in_i = i;
    bus.in_l = l; bus.in_rd = rd; bus.in_rn = rn; bus.in_src = src;
    bus.in_target = AW'(target);
  endtask

  task automatic rand_fields();
    logic [3:0] sup [6] = '{4'h4, 4'h2, 4'h0, 4'hC, 4'hD, 4'hA};
    int r;
    r = $urandom_range(0, 9);
    bus.in_op     = (r < 5) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
    bus.in_cmd    = ($urandom_range(0, 9) < 8) ? sup[$urandom_range(0, 5)] : 4'($urandom);
    bus.in_cond   = 4'($urandom);
    bus.in_s      = 1'($urandom);
    bus.in_i      = 1'($urandom);
    bus.in_l      = 1'($urandom);
    bus.in_rd     = 4'($urandom);
    bus.in_rn     = 4'($urandom);
    bus.in_src    = 12'($urandom);
    bus.in_target = AW'($urandom);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!m_ready && k < 30) begin tick(); k++; end
    if (!m_ready) timeout("wait_ready");
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_phase != 0 && k < 30) begin tick(); k++; end
    if (m_phase != 0) timeout("wait_idle");
  endtask

  time t_acc;

  task automatic send();
    wait_ready();
    bus.in_valid = 1'b1;
    tick();
    t_acc = $time;
    bus.in_valid = 1'b0;
    rand_fields();
    wait_idle();
  endtask

  task automatic do_start(input bit with_valid);
    wait_idle();
    start = 1'b1;
    bus.in_valid = with_valid;
    tick();
    start = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [32:0] e;
    time         t1;
    bus.in_valid = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #2 chk_on = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_count", 32'(wr_count), 0);

    // Pin the model against hand-encoded words.
    e = encode(0, 4'h4, 4'hE, 0, 1, 0, 1, 2, 12'h005, 0, 0);
    chk("model_add", e[31:0], 32'hE282_1005);
    e = encode(0, 4'hA, 4'hE, 0, 0, 0, 7, 3, 12'h004, 0, 0);
    chk("model_cmp", e[31:0], 32'hE153_0004);
    e = encode(1, 4'h0, 4'hE, 0, 0, 1, 0, 1, 12'h008, 0, 0);
    chk("model_ldr", e[31:0], 32'hE591_0008);
    e = encode(2, 4'h0, 4'hE, 0, 0, 0, 0, 0, 12'h000, 0, 3);
    chk("model_b", e[31:0], 32'hEAFF_FFFB);
    e = encode(0, 4'h1, 4'hE, 0, 0, 0, 0, 0, 12'h000, 0, 0);
    chk("model_unsup", 32'(e[32]), 1);

    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("ready_after_rst", 32'(bus.in_ready), 1);

    set_fields(0, 4'h4, 4'hE, 0, 1, 0, 1, 2, 12'h005, 0);
    send();
    chk("add_word", mem[0], 32'hE282_1005);
    chk("add_count", 32'(wr_count), 1);

    set_fields(0, 4'hA, 4'hE, 0, 0, 0, 7, 3, 12'h004, 0);
    send();
    chk("cmp_word", mem[1], 32'hE153_0004);

    do_start(0);
    set_fields(1, 4'h0, 4'hE, 0, 0, 1, 0, 1, 12'h008, 0);
    send();
    t1 = t_acc;
    set_fields(1, 4'h0, 4'hE, 0, 0, 0, 0, 1, 12'h008, 0);
    send();
    chk("ldr_word", mem[0], 32'hE591_0008);
    chk("str_word", mem[1], 32'hE581_0008);
    chk("handshake_gap", 32'((t_acc - t1) / 10), 4);

    do_start(0);
    for (int k = 0; k < 3; k++) begin
      set_fields(0, 4'h4, 4'hE, 0, 1, 0, 0, 0, 12'h000, 0);
      send();
    end
    set_fields(2, 4'h0, 4'hE, 0, 0, 0, 0, 0, 12'h000, 0);
    send();
    chk("branch_word", mem[3], 32'hEAFF_FFFB);

    set_fields(0, 4'h1, 4'hE, 0, 0, 0, 0, 0, 12'h000, 0);
    send();
    chk("unsup_err", 32'(err), 1);
    chk("unsup_code", 32'(err_code), 1);
    chk("unsup_ready", 32'(bus.in_ready), 0);
    chk("unsup_count", 32'(wr_count), 4);
    do_start(1);
    chk("clr_err", 32'(err), 0);
    chk("clr_ready", 32'(bus.in_ready), 1);
    chk("clr_addr", 32'(mem_addr), 0);

    for (int k = 0; k < DEPTH; k++) begin
      set_fields(1, 4'h0, 4'($urandom), 0, 0, 1'($urandom), 4'($urandom), 4'($urandom),
                 12'($urandom), 0);
      send();
    end
    chk("full_flag", 32'(full), 1);
    chk("full_count", 32'(wr_count), DEPTH);
    chk("full_addr", 32'(mem_addr), 0);
    chk("full_ready", 32'(bus.in_ready), 0);
    do_start(0);

    set_fields(0, 4'hC, 4'h0, 1, 0, 0, 5, 6, 12'h009, 0);
    corrupt_mask = 32'h0000_0100;
    send();
    corrupt_mask = 32'h0;
    chk("verify_code", 32'(err_code), 2);
    chk("verify_addr", 32'(mem_addr), 1);
    do_start(0);

    set_fields(0, 4'h4, 4'hE, 0, 1, 0, 1, 2, 12'h005, 0);
    wait_ready();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("midwrite_we", 32'(mem_we), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata2", mem_wdata, 0);
    chk("rst_count2", 32'(wr_count), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ready2", 32'(bus.in_ready), 0);
    tick();
    reset_n = 1'b1;
    tick();

    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (!m_ready || r == 0) begin
        do_start(1'($urandom));
      end else begin
        rand_fields();
        corrupt_mask = ($urandom_range(0, 15) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
        send();
        corrupt_mask = 32'h0;
        if (r == 1) repeat ($urandom_range(1, 3)) tick();
      end
    end

    wait_idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
